// File: rtl/packet_picker.sv
// Per-frame HDMI data-island packet scheduler: buffers audio sample pairs and
// picks ACR / Audio InfoFrame / AVI InfoFrame / Audio Sample / Null per slot.
module packet_picker #(
   parameter int unsigned AUDIO_BIT_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH      = 8
) (
   input  logic                             clk_pixel,
   input  logic                             reset,
   input  logic                             frame_start,
   input  logic                             packet_enable,
   input  logic                             sample_valid,
   input  logic [AUDIO_BIT_WIDTH-1:0]       sample_l,
   input  logic [AUDIO_BIT_WIDTH-1:0]       sample_r,
   output logic [7:0]                       packet_type,
   output logic [8*AUDIO_BIT_WIDTH-1:0]     audio_sample_word,
   output logic [3:0]                       sample_present,
   output logic [3:0]                       sample_b_flag,
   output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
   output logic                             overflow
);

   localparam int unsigned W     = AUDIO_BIT_WIDTH;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [7:0] {
      PKT_NULL  = 8'h00,
      PKT_ACR   = 8'h01,
      PKT_AUDIO = 8'h02,
      PKT_AVI   = 8'h82,
      PKT_AIF   = 8'h84
   } pkt_t;

   // Entry layout {right, left}; subpacket i of audio_sample_word uses the same order.
   logic [2*W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [7:0]       iec_count;
   logic             acr_sent;
   logic             aif_sent;
   logic             avi_sent;

   logic             fifo_full;
   logic             wr_en;
   logic             acr_nxt;
   logic             aif_nxt;
   logic             avi_nxt;
   pkt_t             pkt_nxt;
   logic [2:0]       pop_n;
   logic [8*W-1:0]   words_nxt;
   logic [3:0]       present_nxt;
   logic [3:0]       bflag_nxt;
   logic [7:0]       frame_idx;

   always_comb begin
      fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
      wr_en       = sample_valid && !fifo_full;
      // frame_start clears first so a coincident slot is decided on cleared flags
      acr_nxt     = acr_sent && !frame_start;
      aif_nxt     = aif_sent && !frame_start;
      avi_nxt     = avi_sent && !frame_start;
      pkt_nxt     = PKT_NULL;
      pop_n       = '0;
      words_nxt   = '0;
      present_nxt = '0;
      bflag_nxt   = '0;
      frame_idx   = iec_count;

      if (packet_enable) begin
         if (!acr_nxt) begin
            pkt_nxt = PKT_ACR;
            acr_nxt = 1'b1;
         end else if (!aif_nxt) begin
            pkt_nxt = PKT_AIF;
            aif_nxt = 1'b1;
         end else if (!avi_nxt) begin
            pkt_nxt = PKT_AVI;
            avi_nxt = 1'b1;
         end else if (fifo_count != '0) begin
            pkt_nxt = PKT_AUDIO;
            pop_n   = (fifo_count >= CNT_W'(4)) ? 3'd4 : 3'(fifo_count);
         end
      end

      // IEC frame index may wrap 191->0 between subpackets of one packet
      for (int unsigned i = 0; i < 4; i++) begin
         if (3'(i) < pop_n) begin
            words_nxt[2*W*i +: 2*W] = fifo_mem[rd_ptr + PTR_W'(i)];
            present_nxt[i]          = 1'b1;
            bflag_nxt[i]            = (frame_idx == 8'd0);
            frame_idx               = (frame_idx == 8'd191) ? 8'd0 : frame_idx + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (wr_en && !reset) begin
         fifo_mem[wr_ptr] <= {sample_r, sample_l};
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         fifo_count        <= '0;
         iec_count         <= '0;
         acr_sent          <= 1'b0;
         aif_sent          <= 1'b0;
         avi_sent          <= 1'b0;
         overflow          <= 1'b0;
         packet_type       <= PKT_NULL;
         audio_sample_word <= '0;
         sample_present    <= '0;
         sample_b_flag     <= '0;
      end else begin
         acr_sent   <= acr_nxt;
         aif_sent   <= aif_nxt;
         avi_sent   <= avi_nxt;
         iec_count  <= frame_idx;
         rd_ptr     <= rd_ptr + PTR_W'(pop_n);
         fifo_count <= fifo_count + CNT_W'(wr_en) - CNT_W'(pop_n);
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (sample_valid && fifo_full) begin
            overflow <= 1'b1;
         end
         if (packet_enable) begin
            packet_type       <= pkt_nxt;
            audio_sample_word <= words_nxt;
            sample_present    <= present_nxt;
            sample_b_flag     <= bflag_nxt;
         end
      end
   end

endmodule

// File: doc/packet_picker.md
Name: packet_picker

Overview:
- Per-frame HDMI data-island packet scheduler, placed directly upstream of the hdmi core in the clk_pixel domain.
- Buffers stereo audio sample pairs in a small FIFO.
- On each packet slot (packet_enable from hdmi) it chooses the packet type: Audio Clock Regeneration, Audio InfoFrame, AVI InfoFrame, Audio Sample or Null.
- For audio sample packets it supplies up to four sample pairs plus IEC 60958 block-start (B) flags.
- Replaces ad-hoc scheduling logic in top-level designs.

Parameters:
- AUDIO_BIT_WIDTH, 16, width of each audio sample.
- FIFO_DEPTH, 8, sample-pair FIFO depth; power of two, minimum 4.

Ports:
- clk_pixel  input  1  pixel clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- frame_start  input  1  one-cycle pulse at cx==0 && cy==0.
- packet_enable  input  1  one-cycle pulse from hdmi: packet slot open, type required.
- sample_valid  input  1  a sample pair is presented this cycle (already in clk_pixel domain).
- sample_l  input  AUDIO_BIT_WIDTH  left sample.
- sample_r  input  AUDIO_BIT_WIDTH  right sample.
- packet_type  output  8  type for the hdmi core.
- audio_sample_word  output  4x2xAUDIO_BIT_WIDTH  subpacket i, channel 0=L, 1=R.
- sample_present  output  4  subpacket i holds a valid sample.
- sample_b_flag  output  4  subpacket i sample is IEC frame 0 of a 192-frame block.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  pairs currently buffered.
- overflow  output  1  sticky; a sample was dropped.

Behaviour:
- Reset (synchronous, active-high, overrides all other inputs):
  - packet_type=0x00; audio_sample_word=0; sample_present=0; sample_b_flag=0; overflow=0.
  - FIFO empty; fifo_count=0; IEC frame counter=0.
  - Per-frame flags acr_sent, aif_sent, avi_sent all clear, so the first packet after reset is ACR.
- FIFO write:
  - A write occurs when sample_valid=1 and fifo_count < FIFO_DEPTH. Fullness is evaluated before any same-cycle pop.
  - sample_valid=1 with a full FIFO drops the pair and sets overflow; it stays 1 until reset.
- frame_start clears acr_sent, aif_sent and avi_sent.
  - If packet_enable arrives in the same cycle, the clear takes priority, so the decision sees the cleared flags and issues ACR.
- Decision on packet_enable, in priority order:
  1. !acr_sent -> packet_type=0x01; set acr_sent.
  2. else !aif_sent -> 0x84; set aif_sent.
  3. else !avi_sent -> 0x82; set avi_sent.
  4. else fifo_count>0 -> 0x02; pop n=min(fifo_count,4) pairs, oldest into subpacket 0. sample_present = lowest n bits set. Unused subpacket words are 0.
  5. else -> 0x00.
- Timing:
  - Outputs are registered and update on the edge following the packet_enable cycle (latency 1).
  - Outputs hold until the next packet_enable or reset.
  - For non-audio packets, sample_present=0 and sample_b_flag=0.
- fifo_count updates as count + write - n in the same cycle. A simultaneous write and pop is legal.
- IEC frame counter:
  - Range 0..191; advances by one per popped sample.
  - sample_b_flag[i]=1 when the counter value assigned to subpacket i is 0.
  - Wraps 191->0, possibly in the middle of a packet; e.g. counter 190 with n=4 gives values 190,191,0,1, so b_flag=0100, and the counter becomes 2.
- FIFO read/write pointers wrap modulo FIFO_DEPTH.
- packet_enable pulses faster than one per two cycles are outside the contract.
- Reset in mid-operation discards buffered samples and restarts the scheduling sequence at ACR.

Test Plan:
- Reset, then 4 packet_enable pulses with an empty FIFO -> packet_type sequence 0x01, 0x84, 0x82, 0x00; sample_present=0 throughout.
- After the infoframes, write 6 pairs (L=1..6, R=0x101..0x106), then 2 packet_enables -> first: 0x02, present=1111, L words 1,2,3,4; second: 0x02, present=0011, L words 5,6, others 0; fifo_count ends at 0.
- Write 9 pairs into the depth-8 FIFO with no pops -> fifo_count=8, overflow=1, and the 9th pair never appears in output; overflow stays 1 until reset.
- Pop 190 samples, then write 4 and trigger one packet -> sample_b_flag=0100, and the counter continues at 2.
- Assert frame_start and packet_enable in the same cycle mid-frame -> packet_type=0x01 next cycle; subsequent pulses give 0x84, then 0x82.
- Write and pop in the same cycle with the FIFO full (count 8, pop 4, one write) -> write dropped, overflow=1, fifo_count=4.
